// File: rtl/p0011_scan_ctrl.sv
// Scan sequencer for the Euler 11 adjacent-product search over an N x N grid ROM.
// Optional `define P0011_LOCATION_EN adds best_row/best_col/best_dir outputs.
module p0011_scan_ctrl #(
    parameter int N       = 20,
    parameter int RUN     = 4,
    parameter int DW      = 8,
    parameter int MAX_VAL = 99,
    parameter int RW      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [$clog2(N*N)-1:0]  grid_addr,
    output logic                    grid_rd,
    input  logic [DW-1:0]           grid_data,
    output logic [RW-1:0]           result,
    output logic                    done,
    output logic                    error
`ifdef P0011_LOCATION_EN
    ,
    output logic [4:0]              best_row,
    output logic [4:0]              best_col,
    output logic [1:0]              best_dir
`endif
);

    localparam int AW = $clog2(N*N);
    localparam int CW = $clog2(N);
    localparam int KW = $clog2(RUN+1);

    // Direction codes: 0 right, 1 down-right, 2 down, 3 down-left
    typedef enum logic [2:0] {
        S_IDLE, S_NEXT, S_ISSUE, S_DRAIN, S_COMPARE, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_q, row_d, col_q, col_d;
    logic [1:0]      dir_q, dir_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [RW-1:0]   prod_q, prod_d;
    logic [RW-1:0]   result_q, result_d;
`ifdef P0011_LOCATION_EN
    logic [4:0]      brow_q, brow_d, bcol_q, bcol_d;
    logic [1:0]      bdir_q, bdir_d;
`endif

    logic            fit_row, fit_right, fit_left, win_ok, last_cand;
    logic [AW-1:0]   step, base_addr;
    logic [CW-1:0]   nrow, ncol;
    logic [1:0]      ndir;
    logic [2*RW-1:0] prod_w;
    logic            mul_bad;

    assign fit_row   = (32'(row_q) + RUN - 1) < N;
    assign fit_right = (32'(col_q) + RUN - 1) < N;
    assign fit_left  = 32'(col_q) >= (RUN - 1);
    assign base_addr = AW'(32'(row_q) * N + 32'(col_q));
    assign last_cand = (row_q == CW'(N-1)) && (col_q == CW'(N-1))
                    && (dir_q == 2'd3);

    assign prod_w  = (2*RW)'(prod_q) * (2*RW)'(grid_data);
    assign mul_bad = (grid_data > DW'(MAX_VAL))
                  || (prod_w[2*RW-1:RW] != '0);

    always_comb begin
        win_ok = 1'b0;
        step   = '0;
        unique case (dir_q)
            2'd0: begin win_ok = fit_right;            step = AW'(1);   end
            2'd1: begin win_ok = fit_row && fit_right; step = AW'(N+1); end
            2'd2: begin win_ok = fit_row;              step = AW'(N);   end
            2'd3: begin win_ok = fit_row && fit_left;  step = AW'(N-1); end
        endcase
    end

    always_comb begin
        nrow = row_q;
        ncol = col_q;
        ndir = dir_q + 2'd1;
        if (dir_q == 2'd3) begin
            if (col_q == CW'(N-1)) begin
                ncol = '0;
                nrow = row_q + CW'(1);
            end else begin
                ncol = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        dir_d    = dir_q;
        k_d      = k_q;
        addr_d   = addr_q;
        prod_d   = prod_q;
        result_d = result_q;
`ifdef P0011_LOCATION_EN
        brow_d   = brow_q;
        bcol_d   = bcol_q;
        bdir_d   = bdir_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    result_d = '0;
                    row_d    = '0;
                    col_d    = '0;
                    dir_d    = '0;
`ifdef P0011_LOCATION_EN
                    brow_d   = '0;
                    bcol_d   = '0;
                    bdir_d   = '0;
`endif
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (win_ok) begin
                    prod_d  = RW'(1);
                    k_d     = '0;
                    addr_d  = base_addr;
                    state_d = S_ISSUE;
                end else if (last_cand) begin
                    state_d = S_DONE;
                end else begin
                    row_d = nrow;
                    col_d = ncol;
                    dir_d = ndir;
                end
            end
            S_ISSUE: begin
                addr_d = addr_q + step;
                k_d    = k_q + KW'(1);
                if (k_q == KW'(RUN-1))
                    state_d = S_DRAIN;
                if (k_q != '0) begin
                    prod_d = prod_w[RW-1:0];
                    if (mul_bad)
                        state_d = S_ERR;
                end
            end
            S_DRAIN: begin
                prod_d  = prod_w[RW-1:0];
                state_d = mul_bad ? S_ERR : S_COMPARE;
            end
            S_COMPARE: begin
                if (prod_q > result_q) begin
                    result_d = prod_q;
`ifdef P0011_LOCATION_EN
                    brow_d   = 5'(row_q);
                    bcol_d   = 5'(col_q);
                    bdir_d   = dir_q;
`endif
                end
                if (last_cand) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = nrow;
                    col_d   = ncol;
                    dir_d   = ndir;
                    state_d = S_NEXT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            dir_q    <= '0;
            k_q      <= '0;
            addr_q   <= '0;
            prod_q   <= '0;
            result_q <= '0;
`ifdef P0011_LOCATION_EN
            brow_q   <= '0;
            bcol_q   <= '0;
            bdir_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dir_q    <= dir_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            prod_q   <= prod_d;
            result_q <= result_d;
`ifdef P0011_LOCATION_EN
            brow_q   <= brow_d;
            bcol_q   <= bcol_d;
            bdir_q   <= bdir_d;
`endif
        end
    end

    assign grid_rd   = (state_q == S_ISSUE);
    assign grid_addr = addr_q;
    assign result    = result_q;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
`ifdef P0011_LOCATION_EN
    assign best_row  = brow_q;
    assign best_col  = bcol_q;
    assign best_dir  = bdir_q;
`endif

endmodule

// File: tb/tb_p0011_scan_ctrl.sv
// Scoreboard bench for p0011_scan_ctrl: launches scans, monitor checks each completion.
// Location outputs are checked when P0011_LOCATION_EN is defined.
module tb_p0011_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  grid_addr;
    logic        grid_rd;
    logic [7:0]  grid_data = '0;
    logic [31:0] result;
    logic        done, error;
`ifdef P0011_LOCATION_EN
    logic [4:0]  best_row, best_col;
    logic [1:0]  best_dir;
`endif

    p0011_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .grid_addr(grid_addr), .grid_rd(grid_rd), .grid_data(grid_data),
        .result(result), .done(done), .error(error)
`ifdef P0011_LOCATION_EN
        , .best_row(best_row), .best_col(best_col), .best_dir(best_dir)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        bit          dn;
        bit          er;
        int          cycles;
        int          rds;
        int          brow;
        int          bcol;
        int          bdir;
        int          sedge;
        int          rdb;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rd_cnt = 0;
    bit   flag_q = 1'b0;

    logic [7:0] grid [400];
    logic [7:0] eul [400] = '{
        08,02,22,97,38,15,00,40,00,75,04,05,07,78,52,12,50,77,91,08,
        49,49,99,40,17,81,18,57,60,87,17,40,98,43,69,48,04,56,62,00,
        81,49,31,73,55,79,14,29,93,71,40,67,53,88,30,03,49,13,36,65,
        52,70,95,23,04,60,11,42,69,24,68,56,01,32,56,71,37,02,36,91,
        22,31,16,71,51,67,63,89,41,92,36,54,22,40,40,28,66,33,13,80,
        24,47,32,60,99,03,45,02,44,75,33,53,78,36,84,20,35,17,12,50,
        32,98,81,28,64,23,67,10,26,38,40,67,59,54,70,66,18,38,64,70,
        67,26,20,68,02,62,12,20,95,63,94,39,63,08,40,91,66,49,94,21,
        24,55,58,05,66,73,99,26,97,17,78,78,96,83,14,88,34,89,63,72,
        21,36,23,09,75,00,76,44,20,45,35,14,00,61,33,97,34,31,33,95,
        78,17,53,28,22,75,31,67,15,94,03,80,04,62,16,14,09,53,56,92,
        16,39,05,42,96,35,31,47,55,58,88,24,00,17,54,24,36,29,85,57,
        86,56,00,48,35,71,89,07,05,44,44,37,44,60,21,58,51,54,17,58,
        19,80,81,68,05,94,47,69,28,73,92,13,86,52,17,77,04,89,55,40,
        04,52,08,83,97,35,99,16,07,97,57,32,16,26,26,79,33,27,98,66,
        88,36,68,87,57,62,20,72,03,46,33,67,46,55,12,32,63,93,53,69,
        04,42,16,73,38,25,39,11,24,94,72,18,08,46,29,32,40,62,76,36,
        20,69,36,41,72,30,23,88,34,62,99,69,82,67,59,85,74,04,36,16,
        20,73,35,29,78,31,90,01,74,31,49,71,48,86,81,16,23,57,05,54,
        01,70,54,71,83,51,54,69,16,92,33,48,61,43,52,01,89,19,67,48
    };

    // Synchronous ROM: data valid the cycle after the read strobe
    always @(posedge clk)
        if (grid_rd) grid_data <= grid[grid_addr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation on each rising done/error
    always @(negedge clk) begin
        exp_t e;
        if (grid_rd) rd_cnt++;
        if (rst) begin
            flag_q = 1'b0;
        end else begin
            if ((done || error) && !flag_q) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_end: got done=%0d error=%0d expected none",
                             done, error);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_done"}, done, e.dn);
                    chk({e.name, "_error"}, error, e.er);
                    chk({e.name, "_excl"}, done & error, 0);
                    if (e.cycles >= 0)
                        chk({e.name, "_cycles"}, cyc - e.sedge, e.cycles);
                    if (e.rds >= 0)
                        chk({e.name, "_rds"}, rd_cnt - e.rdb, e.rds);
`ifdef P0011_LOCATION_EN
                    chk({e.name, "_brow"}, best_row, e.brow);
                    chk({e.name, "_bcol"}, best_col, e.bcol);
                    chk({e.name, "_bdir"}, best_dir, e.bdir);
`endif
                end
            end
            flag_q = done || error;
        end
    end

    task automatic fill(input int v);
        for (int i = 0; i < 400; i++) grid[i] = 8'(v);
    endtask

    task automatic setc(input int r, input int c, input int v);
        grid[r*20 + c] = 8'(v);
    endtask

    task automatic launch(input string nm, input logic [31:0] r,
                          input bit dn, input bit er, input int cycles,
                          input int rds, input int br, input int bc,
                          input int bd);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        e = '{name: nm, res: r, dn: dn, er: er, cycles: cycles, rds: rds,
              brow: br, bcol: bc, bdir: bd, sedge: cyc + 1, rdb: rd_cnt};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 20000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1;
        chk("rst_result", result, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd", grid_rd, 0);
        chk("rst_addr", grid_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        fill(1);
        launch("ones", 32'd1, 1, 0, 9148, 5032, 0, 0, 0);
        repeat (1000) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ones");

        fill(0);
        setc(5, 3, 99); setc(6, 4, 99); setc(7, 5, 99); setc(8, 6, 99);
        launch("dr99", 32'd96059601, 1, 0, 9148, 5032, 5, 3, 1);
        wait_idle("dr99");

        fill(0);
        setc(0, 19, 50); setc(1, 18, 50); setc(2, 17, 50); setc(3, 16, 50);
        launch("dl50", 32'd6250000, 1, 0, 9148, 5032, 0, 19, 3);
        wait_idle("dl50");

        fill(1);
        grid[37] = 8'd100;
        launch("illegal", 32'd1, 0, 1, -1, -1, 0, 0, 0);
        wait_idle("illegal");

        for (int i = 0; i < 400; i++) grid[i] = eul[i];
        launch("euler", 32'd70600674, 1, 0, 9148, 5032, 12, 6, 3);
        wait_idle("euler");

        fill(1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3000) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_result", result, 0);
        chk("abort_done", done, 0);
        chk("abort_error", error, 0);
        chk("abort_rd", grid_rd, 0);
        chk("abort_addr", grid_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_rd", grid_rd, 0);
        chk("idle_result", result, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/p0011_scan_ctrl.md
Name: p0011_scan_ctrl

Overview:
- Sequencing controller for the Problem 11 datapath: finds the greatest product of RUN adjacent grid values in an N×N grid.
- Directions covered: right, down, diagonal down-right, diagonal down-left.
- Walks every start cell and direction, issues grid reads to a synchronous grid ROM, accumulates the window product, and tracks the maximum.
- Exposes the same result/done/error contract as the other Euler solver cores, plus start/reset so a top-level runner can re-launch it.

Parameters:
- N, 20, grid side length.
- RUN, 4, adjacent cells per window.
- DW, 8, grid data width.
- MAX_VAL, 99, largest legal grid value.
- RW, 32, result/product width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle launch pulse, sampled only in IDLE/DONE/ERR.
- grid_addr  out  $clog2(N*N)  row-major address, row*N+col.
- grid_rd  out  1  read strobe.
- grid_data  in  DW  ROM data, valid exactly 1 cycle after the grid_rd cycle.
- result  out  RW  maximum product found.
- done  out  1  high (level) once the scan completes without error.
- error  out  1  high (level) on illegal data or product overflow.

Behaviour:
- Reset (async) values: state=IDLE; result=0, done=0, error=0, grid_rd=0, grid_addr=0; all counters cleared. Reset mid-scan aborts immediately with no partial result.
- States: IDLE, NEXT, ISSUE, DRAIN, COMPARE, DONE, ERR.
- IDLE/DONE/ERR, start=1: clear result/done/error, set cand (row=0, col=0, dir=0), go to NEXT. start is ignored in all other states.
- NEXT (1 cycle per candidate):
  - Test window bounds: right col+RUN-1<N; down row+RUN-1<N; diag-dr both; diag-dl row+RUN-1<N and col>=RUN-1.
  - Valid: product=1, k=0, go to ISSUE.
  - Invalid: advance the candidate.
  - Candidate order: dir fastest (0..3), then col, then row.
  - Invalid candidate that is the last one (row=N-1, col=N-1, dir=3): go to DONE.
- ISSUE (RUN cycles): grid_rd=1, grid_addr = start + k*step.
  - Step: right 1, down N, dr N+1, dl N-1.
  - Each cycle with k>=1: multiply product by the previous cycle's grid_data.
- DRAIN (1 cycle): grid_rd=0; multiply in the final grid_data.
- Multiply rule: computed at 2*RW bits.
  - Any grid_data>MAX_VAL: go to ERR.
  - Any upper-half bit set: go to ERR.
- COMPARE (1 cycle): if product>result (unsigned), result=product. Then advance the candidate and go to NEXT, or go to DONE if it was the last candidate.
- DONE: done=1, result held.
- ERR: error=1, done=0; result holds the max reached before the fault.
- done and error are never both 1.
- Latency (N=20, RUN=4): the scan has 1600 candidates and 1258 valid windows.
  - Cycles = 1600 + 1258*(RUN+2) = 9148 edges from the start-sampling edge to the edge that sets done.
- No multiplier pipelining; one window in flight at a time.

Optional Feature:
- P0011_LOCATION_EN defined: adds outputs best_row (5 bits), best_col (5 bits), best_dir (2 bits). These update in COMPARE together with result on a strictly greater product; ties keep the first window found. Reset value 0; cleared on start.
- Macro undefined: ports absent, no extra registers; all other behaviour identical.

Test Plan:
- All-ones grid, start pulse → done=1 exactly 9148 edges after start; result=1; error=0; grid_rd high 5032 cycles total.
- Grid zero except 99 at (5,3),(6,4),(7,5),(8,6) → result=96059601. With P0011_LOCATION_EN: best_row=5, best_col=3, best_dir=1 (dr).
- Grid zero except 50 at (0,19),(1,18),(2,17),(3,16) → result=6250000 via diag-dl. With the macro: best_row=0, best_col=19, best_dir=3.
- Official Euler 11 grid → result=70600674, done=1, error=0.
- grid_data=100 at address 37 → error=1, done=0; a later start with a legal grid completes normally with error cleared.
- rst pulsed at cycle 3000 of a scan → all outputs 0 and state IDLE asynchronously. A start pulse during an active scan is ignored: the done count is unchanged at 9148.
